// File: rtl/pc_stack_pkg.sv
// Shared definitions for the pc_stack program counter: operation codes and request priority.
// Build option PC_REL_EN (see pc_stack.sv) does not affect this package.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_RET  = 3'd2,
        OP_CALL = 3'd3,
        OP_LOAD = 3'd4
    } op_e;

    // Only the highest-priority request executes; the others are dropped for the cycle.
    function automatic op_e prio_encode(input logic load, input logic call,
                                        input logic ret, input logic inc);
        op_e op;
        if (load) begin
            op = OP_LOAD;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (inc) begin
            op = OP_INC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the fetch unit (master) and pc_stack (slave).
// With PC_REL_EN defined the bundle also carries the rel (PC-relative target) strobe.
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
`ifdef PC_REL_EN
    logic             rel;
`endif
    logic [WIDTH-1:0] out;
    logic [SPW-1:0]   sp;
    logic             empty;
    logic             full;
    logic             err;

    modport master (
`ifdef PC_REL_EN
        output rel,
`endif
        output in, load, inc, call, ret,
        input  out, sp, empty, full, err
    );

    modport slave (
`ifdef PC_REL_EN
        input  rel,
`endif
        input  in, load, inc, call, ret,
        output out, sp, empty, full, err
    );

endinterface

// File: rtl/lifo_stack.sv
// Return-address LIFO for pc_stack: storage, stack pointer and full/empty status.
// Callers must not push while full or pop while empty; such requests are ignored here.
module lifo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      push_data,
    output logic [WIDTH-1:0]      top_data,
    output logic [$clog2(DEPTH):0] sp,
    output logic                  empty,
    output logic                  full
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [SPW-1:0]   sp_r;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;

    // At sp == DEPTH the low bits wrap to 0, so rd_idx still lands on DEPTH-1.
    assign wr_idx_s = sp_r[AW-1:0];
    assign rd_idx_s = wr_idx_s - AW'(1'b1);

    assign empty    = (sp_r == {SPW{1'b0}});
    assign full     = (sp_r == SPW'(DEPTH));
    assign sp       = sp_r;
    assign top_data = mem_r[rd_idx_s];

    // Stack pointer: the only reset state in the LIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_r <= {SPW{1'b0}};
        end else if (push && !full) begin
            sp_r <= sp_r + SPW'(1'b1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - SPW'(1'b1);
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage, deliberately left uninitialised by reset.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware call/return stack (load > call > ret > inc > hold).
// Define PC_REL_EN to add the rel strobe that makes load/call targets out + in.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    pc_stack_if.slave    bus
);
    localparam int SPW = $clog2(DEPTH) + 1;

    op_e              op_s;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt_s;
    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [WIDTH-1:0] top_s;
    logic [SPW-1:0]   sp_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;

    assign op_s       = prio_encode(bus.load, bus.call, bus.ret, bus.inc);
    assign ret_addr_s = out_r + WIDTH'(1'b1);

`ifdef PC_REL_EN
    assign target_s = bus.rel ? (out_r + bus.in) : bus.in;
`else
    assign target_s = bus.in;
`endif

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (ret_addr_s),
        .top_data  (top_s),
        .sp        (sp_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Next-PC select, stack control and error detection for the winning request.
    always_comb begin
        out_nxt_s = out_r;
        err_nxt_s = err_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (op_s)
            OP_LOAD: begin
                out_nxt_s = target_s;
            end
            OP_CALL: begin
                if (full_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    push_s    = 1'b1;
                    out_nxt_s = target_s;
                end
            end
            OP_RET: begin
                if (empty_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    pop_s     = 1'b1;
                    out_nxt_s = top_s;
                end
            end
            OP_INC: begin
                out_nxt_s = ret_addr_s;
            end
            default: begin
                out_nxt_s = out_r;
            end
        endcase
    end

    // PC and sticky error registers; err only clears on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_r <= {WIDTH{1'b0}};
            err_r <= 1'b0;
        end else begin
            out_r <= out_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    assign bus.out   = out_r;
    assign bus.sp    = sp_s;
    assign bus.empty = empty_s;
    assign bus.full  = full_s;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack (WIDTH=16, DEPTH=4); relative-target vectors run when PC_REL_EN is defined.
`timescale 1ns/1ps
module tb_pc_stack;

    typedef struct packed {
        logic [15:0] out;
        logic [2:0]  sp;
        logic        err;
        logic        empty;
        logic        full;
    } exp_t;

    typedef struct {
        int    cyc;
        string name;
        exp_t  e;
    } sb_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb[$];
`ifdef PC_REL_EN
    logic tb_rel = 1'b0;
`endif

    pc_stack_if #(.WIDTH(16), .DEPTH(4)) bus ();

    pc_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #2 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [15:0] o, input logic [2:0] s, input logic e);
        exp_t r;
        r.out   = o;
        r.sp    = s;
        r.err   = e;
        r.empty = (s == 3'd0);
        r.full  = (s == 3'd4);
        return r;
    endfunction

    function automatic exp_t dut_now();
        exp_t r;
        r.out   = bus.out;
        r.sp    = bus.sp;
        r.err   = bus.err;
        r.empty = bus.empty;
        r.full  = bus.full;
        return r;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%h sp=%0d err=%b empty=%b full=%b, want out=%h sp=%0d err=%b empty=%b full=%b",
                     name, act.out, act.sp, act.err, act.empty, act.full,
                     exp.out, exp.sp, exp.err, exp.empty, exp.full);
        end
    endtask

    // Monitor: outputs settle after the posedge; compare the entries due this cycle.
    always @(negedge clock) begin
        sb_t ent;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ent = sb.pop_front();
            check(ent.name, dut_now(), ent.e);
        end
    end

    task automatic op(input string name, input logic l, input logic i, input logic c,
                      input logic r, input logic [15:0] d, input exp_t e);
        sb_t ent;
        @(posedge clock);
        #1;
        bus.load = l;
        bus.inc  = i;
        bus.call = c;
        bus.ret  = r;
        bus.in   = d;
`ifdef PC_REL_EN
        bus.rel  = tb_rel;
`endif
        ent.cyc  = cyc + 1;
        ent.name = name;
        ent.e    = e;
        sb.push_back(ent);
    endtask

    task automatic do_reset(input string name);
        @(posedge clock);
        @(negedge clock);
        #1;
        reset_n  = 1'b0;
        #0.5;
        check(name, dut_now(), mk(16'd0, 3'd0, 1'b0));
        bus.load = 1'b0;
        bus.inc  = 1'b0;
        bus.call = 1'b0;
        bus.ret  = 1'b0;
        @(negedge clock);
        #1;
        reset_n  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in   = 16'd0;
        bus.load = 1'b0;
        bus.inc  = 1'b0;
        bus.call = 1'b0;
        bus.ret  = 1'b0;
`ifdef PC_REL_EN
        bus.rel  = 1'b0;
`endif
        #5;
        check("reset_state", dut_now(), mk(16'd0, 3'd0, 1'b0));
        @(negedge clock);
        #1;
        reset_n = 1'b1;

        for (int k = 1; k <= 9; k++) op("count", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, mk(16'(k), 3'd0, 1'b0));
        do_reset("async_reset_mid_count");

        for (int k = 1; k <= 5; k++) op("inc", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, mk(16'(k), 3'd0, 1'b0));
        op("load7",        1'b1, 1'b0, 1'b0, 1'b0, 16'd7,  mk(16'd7,  3'd0, 1'b0));
        op("load_inc7",    1'b1, 1'b1, 1'b0, 1'b0, 16'd7,  mk(16'd7,  3'd0, 1'b0));
        op("load_inc30",   1'b1, 1'b1, 1'b0, 1'b0, 16'd30, mk(16'd30, 3'd0, 1'b0));

        op("load10",       1'b1, 1'b0, 1'b0, 1'b0, 16'd10,  mk(16'd10,  3'd0, 1'b0));
        op("call100",      1'b0, 1'b0, 1'b1, 1'b0, 16'd100, mk(16'd100, 3'd1, 1'b0));
        op("ret_to11",     1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   mk(16'd11,  3'd0, 1'b0));

        op("call200",      1'b0, 1'b0, 1'b1, 1'b0, 16'd200, mk(16'd200, 3'd1, 1'b0));
        op("call300",      1'b0, 1'b0, 1'b1, 1'b0, 16'd300, mk(16'd300, 3'd2, 1'b0));
        op("call400",      1'b0, 1'b0, 1'b1, 1'b0, 16'd400, mk(16'd400, 3'd3, 1'b0));
        op("call450_full", 1'b0, 1'b0, 1'b1, 1'b0, 16'd450, mk(16'd450, 3'd4, 1'b0));
        op("call_overflow",1'b0, 1'b0, 1'b1, 1'b0, 16'd500, mk(16'd450, 3'd4, 1'b1));
        op("ret_401",      1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   mk(16'd401, 3'd3, 1'b1));
        op("ret_301",      1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   mk(16'd301, 3'd2, 1'b1));
        op("ret_201",      1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   mk(16'd201, 3'd1, 1'b1));
        op("ret_12",       1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   mk(16'd12,  3'd0, 1'b1));
        do_reset("reset_clears_err");

        op("ret_underflow",1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  mk(16'd0,  3'd0, 1'b1));
        op("load5_err",    1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  mk(16'd5,  3'd0, 1'b1));
        op("load_call_nopush", 1'b1, 1'b0, 1'b1, 1'b0, 16'd40, mk(16'd40, 3'd0, 1'b1));
        op("inc_41",       1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  mk(16'd41, 3'd0, 1'b1));
        op("call_ret_call",1'b0, 1'b0, 1'b1, 1'b1, 16'd60, mk(16'd60, 3'd1, 1'b1));
        op("hold",         1'b0, 1'b0, 1'b0, 1'b0, 16'd99, mk(16'd60, 3'd1, 1'b1));
        op("ret_42",       1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  mk(16'd42, 3'd0, 1'b1));
        do_reset("reset_clears_err2");

        op("load_ffff",    1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, mk(16'hFFFF, 3'd0, 1'b0));
        op("inc_wrap",     1'b0, 1'b1, 1'b0, 1'b0, 16'd0,    mk(16'd0,     3'd0, 1'b0));
        op("call_at_ffff_prep", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, mk(16'hFFFF, 3'd0, 1'b0));
        op("call_wrap_push", 1'b0, 1'b0, 1'b1, 1'b0, 16'd8,  mk(16'd8, 3'd1, 1'b0));
        op("ret_wrap_0",   1'b0, 1'b0, 1'b0, 1'b1, 16'd0,    mk(16'd0, 3'd0, 1'b0));
`ifdef PC_REL_EN
        op("load20",       1'b1, 1'b0, 1'b0, 1'b0, 16'd20,   mk(16'd20, 3'd0, 1'b0));
        tb_rel = 1'b1;
        op("rel_load_m5",  1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFB, mk(16'd15, 3'd0, 1'b0));
        op("rel_call_p3",  1'b0, 1'b0, 1'b1, 1'b0, 16'd3,    mk(16'd18, 3'd1, 1'b0));
        tb_rel = 1'b0;
        op("ret_16",       1'b0, 1'b0, 1'b0, 1'b1, 16'd0,    mk(16'd16, 3'd0, 1'b0));
`endif
        op("final_hold",   1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    mk(dut_hold_value(), 3'd0, 1'b0));

        repeat (4) @(negedge clock);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Value the PC should be parked at before the closing hold.
    function automatic logic [15:0] dut_hold_value();
`ifdef PC_REL_EN
        return 16'd16;
`else
        return 16'd0;
`endif
    endfunction

endmodule
